// File: rtl/clock_divider_ctrl.sv
// clock_divider_ctrl
//   Run-time programmable clock-waveform controller. Produces a registered
//   divided waveform with programmable period and high time. It sequences
//   start/stop and applies new settings only at period boundaries, so the
//   waveform never glitches. Configuration uses a valid/ready handshake.
//
// Ports
//   clock_i        sole clock, rising edge
//   reset_i        synchronous active-high reset
//   start_i        begin generating (from idle, or resume while draining)
//   stop_i         finish the current period, then go idle
//   cfg_valid_i    configuration request
//   cfg_ready_o    configuration can be accepted this cycle (independent of valid)
//   cfg_period_i   requested period in clock cycles
//   cfg_high_i     requested high cycles per period
//   cfg_err_o      one-cycle pulse: accepted configuration was invalid and discarded
//   out_o          generated waveform (registered)
//   period_tick_o  one-cycle pulse in the last cycle of each period
//   busy_o         high while running or draining
module clock_divider_ctrl #(
  parameter int unsigned CNT_W          = 8,
  parameter int unsigned DEFAULT_PERIOD = 4,
  parameter int unsigned DEFAULT_HIGH   = 1
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             cfg_valid_i,
  output logic             cfg_ready_o,
  input  logic [CNT_W-1:0] cfg_period_i,
  input  logic [CNT_W-1:0] cfg_high_i,
  output logic             cfg_err_o,
  output logic             out_o,
  output logic             period_tick_o,
  output logic             busy_o
);

  localparam logic [CNT_W-1:0] One       = CNT_W'(1);
  localparam logic [CNT_W-1:0] Two       = CNT_W'(2);
  localparam logic [CNT_W-1:0] DefPeriod = CNT_W'(DEFAULT_PERIOD);
  localparam logic [CNT_W-1:0] DefHigh   = CNT_W'(DEFAULT_HIGH);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] pend_period_q, pend_period_d;
  logic [CNT_W-1:0] pend_high_q, pend_high_d;
  logic             cfg_err_q, cfg_err_d;

  logic busy;
  logic last;
  logic xfer;
  logic cfg_ok;

  always_comb begin
    busy        = (state_q != StIdle);
    last        = (cnt_q == period_q - One);
    cfg_ready_o = (state_q == StIdle) || !pend_q;
    xfer        = cfg_valid_i && cfg_ready_o;
    cfg_ok      = (cfg_period_i >= Two) && (cfg_high_i != '0) && (cfg_high_i < cfg_period_i);
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_i && !stop_i) state_d = StRun;
      StRun:   if (stop_i) state_d = StDrain;
      StDrain: begin
        if (start_i && !stop_i) state_d = StRun;
        else if (last)          state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Configuration: direct load when idle, otherwise staged until the boundary.
  always_comb begin
    period_d      = period_q;
    high_d        = high_q;
    pend_d        = pend_q;
    pend_period_d = pend_period_q;
    pend_high_d   = pend_high_q;
    cfg_err_d     = xfer && !cfg_ok;
    if (state_q == StIdle) begin
      if (xfer && cfg_ok) begin
        period_d = cfg_period_i;
        high_d   = cfg_high_i;
      end
    end else if (last) begin
      // A pending config blocks ready, so a boundary transfer only occurs with nothing pending.
      if (pend_q) begin
        period_d = pend_period_q;
        high_d   = pend_high_q;
        pend_d   = 1'b0;
      end else if (xfer && cfg_ok) begin
        period_d = cfg_period_i;
        high_d   = cfg_high_i;
      end
    end else if (xfer && cfg_ok) begin
      pend_d        = 1'b1;
      pend_period_d = cfg_period_i;
      pend_high_d   = cfg_high_i;
    end
  end

  // Counter and waveform; out follows the counter value it will hold next cycle.
  always_comb begin
    cnt_d = '0;
    if (state_q != StIdle && state_d != StIdle && !last) begin
      cnt_d = cnt_q + One;
    end
    out_d = (state_d != StIdle) && (cnt_d < high_d);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      out_q         <= 1'b0;
      period_q      <= DefPeriod;
      high_q        <= DefHigh;
      pend_q        <= 1'b0;
      pend_period_q <= '0;
      pend_high_q   <= '0;
      cfg_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      out_q         <= out_d;
      period_q      <= period_d;
      high_q        <= high_d;
      pend_q        <= pend_d;
      pend_period_q <= pend_period_d;
      pend_high_q   <= pend_high_d;
      cfg_err_q     <= cfg_err_d;
    end
  end

  assign out_o         = out_q;
  assign cfg_err_o     = cfg_err_q;
  assign busy_o        = busy;
  assign period_tick_o = busy && last;

endmodule

// File: tb/tb_clock_divider_ctrl.sv
// Testbench for clock_divider_ctrl. The driver applies one input vector per
// cycle and queues the outputs expected during that cycle as
// {out, period_tick, busy, cfg_ready, cfg_err}; the monitor pops and compares
// on every falling edge.
module tb_clock_divider_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       stop;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_period;
  logic [7:0] cfg_high;
  logic       cfg_err;
  logic       out;
  logic       period_tick;
  logic       busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0] v;
    string      name;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  clock_divider_ctrl #(
    .CNT_W         (8),
    .DEFAULT_PERIOD(4),
    .DEFAULT_HIGH  (1)
  ) dut (
    .clock_i      (clk),
    .reset_i      (reset),
    .start_i      (start),
    .stop_i       (stop),
    .cfg_valid_i  (cfg_valid),
    .cfg_ready_o  (cfg_ready),
    .cfg_period_i (cfg_period),
    .cfg_high_i   (cfg_high),
    .cfg_err_o    (cfg_err),
    .out_o        (out),
    .period_tick_o(period_tick),
    .busy_o       (busy)
  );

  // Monitor
  always @(negedge clk) begin
    exp_t       e;
    logic [4:0] act;
    if (exp_q.size() != 0) begin
      e   = exp_q.pop_front();
      act = {out, period_tick, busy, cfg_ready, cfg_err};
      checks++;
      if (act !== e.v) begin
        errors++;
        $display("FAIL %s @%0t: out/tick/busy/rdy/err got %b expected %b",
                 e.name, $time, act, e.v);
      end
    end
  end

  task automatic cyc(input logic rst, input logic st, input logic sp, input logic cv,
                     input logic [7:0] cp, input logic [7:0] ch,
                     input logic [4:0] e, input string nm);
    exp_t x;
    @(posedge clk);
    #1;
    reset      = rst;
    start      = st;
    stop       = sp;
    cfg_valid  = cv;
    cfg_period = cp;
    cfg_high   = ch;
    x.v        = e;
    x.name     = nm;
    exp_q.push_back(x);
  endtask

  task automatic idle_cyc(input logic [4:0] e, input string nm);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, e, nm);
  endtask

  // Full periods of the 4/1 waveform with no pending config.
  task automatic wave41(input int n, input string nm);
    for (int p = 0; p < n; p++) begin
      idle_cyc(5'b10110, nm);
      idle_cyc(5'b00110, nm);
      idle_cyc(5'b00110, nm);
      idle_cyc(5'b01110, nm);
    end
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    stop       = 1'b0;
    cfg_valid  = 1'b0;
    cfg_period = '0;
    cfg_high   = '0;
    repeat (2) @(posedge clk);

    // Reset state, then default 25% waveform
    idle_cyc(5'b00010, "reset_state");
    cyc(0, 1, 0, 0, 8'd0, 8'd0, 5'b00010, "start_idle");
    wave41(2, "default_4_1");
    // start while running has no effect
    cyc(0, 1, 0, 0, 8'd0, 8'd0, 5'b10110, "start_in_run");
    idle_cyc(5'b00110, "start_in_run");
    idle_cyc(5'b00110, "start_in_run");
    idle_cyc(5'b01110, "start_in_run");

    // Invalid configs: 1/0, 4/0, 4/4
    cyc(0, 0, 0, 1, 8'd1, 8'd0, 5'b10110, "bad_cfg_1_0");
    cyc(0, 0, 0, 1, 8'd4, 8'd0, 5'b00111, "bad_cfg_4_0");
    cyc(0, 0, 0, 1, 8'd4, 8'd4, 5'b00111, "bad_cfg_4_4");
    idle_cyc(5'b01111, "bad_cfg_err3");
    wave41(1, "after_bad_cfg");

    // Stop at cnt=1, drain, idle
    idle_cyc(5'b10110, "stop_cnt0");
    cyc(0, 0, 1, 0, 8'd0, 8'd0, 5'b00110, "stop_cnt1");
    idle_cyc(5'b00110, "drain_cnt2");
    idle_cyc(5'b01110, "drain_cnt3");
    idle_cyc(5'b00010, "idle_after_drain");
    idle_cyc(5'b00010, "idle_after_drain");

    // Restart, stop, then resume from DRAIN at cnt=2
    cyc(0, 1, 0, 0, 8'd0, 8'd0, 5'b00010, "restart");
    idle_cyc(5'b10110, "restart_cnt0");
    cyc(0, 0, 1, 0, 8'd0, 8'd0, 5'b00110, "stop2_cnt1");
    cyc(0, 1, 0, 0, 8'd0, 8'd0, 5'b00110, "resume_cnt2");
    idle_cyc(5'b01110, "resume_cnt3");

    // Pending config 6/3 taken at cnt=1
    idle_cyc(5'b10110, "pend_cnt0");
    cyc(0, 0, 0, 1, 8'd6, 8'd3, 5'b00110, "pend_xfer");
    idle_cyc(5'b00100, "pend_wait_cnt2");
    idle_cyc(5'b01100, "pend_wait_cnt3");
    for (int i = 0; i < 6; i++)
      idle_cyc(i < 3 ? 5'b10110 : (i == 5 ? 5'b01110 : 5'b00110), "wave_6_3");
    cyc(0, 0, 1, 0, 8'd0, 8'd0, 5'b10110, "stop_6_3");
    for (int i = 1; i < 6; i++)
      idle_cyc(i < 3 ? 5'b10110 : (i == 5 ? 5'b01110 : 5'b00110), "drain_6_3");
    idle_cyc(5'b00010, "idle_after_6_3");

    // Config 10/5 together with start in IDLE
    cyc(0, 1, 0, 1, 8'd10, 8'd5, 5'b00010, "start_with_cfg");
    for (int i = 0; i < 10; i++)
      idle_cyc(i < 5 ? 5'b10110 : (i == 9 ? 5'b01110 : 5'b00110), "wave_10_5");
    for (int i = 0; i < 9; i++)
      idle_cyc(i < 5 ? 5'b10110 : 5'b00110, "wave_10_5_b");
    // Transfer on the boundary cycle applies to the very next period
    cyc(0, 0, 0, 1, 8'd4, 8'd1, 5'b01110, "boundary_xfer");
    // start && stop together: stop wins
    cyc(0, 1, 1, 0, 8'd0, 8'd0, 5'b10110, "start_stop_run");
    idle_cyc(5'b00110, "start_stop_drain");
    idle_cyc(5'b00110, "start_stop_drain");
    idle_cyc(5'b01110, "start_stop_drain");
    cyc(0, 1, 1, 0, 8'd0, 8'd0, 5'b00010, "start_stop_idle");
    idle_cyc(5'b00010, "start_stop_idle");

    // Reset mid-run with a pending config; defaults must come back
    cyc(0, 0, 0, 1, 8'd10, 8'd5, 5'b00010, "idle_cfg_10_5");
    cyc(0, 1, 0, 0, 8'd0, 8'd0, 5'b00010, "start_10_5");
    idle_cyc(5'b10110, "run_10_5_cnt0");
    cyc(0, 0, 0, 1, 8'd6, 8'd3, 5'b10110, "pend_before_rst");
    cyc(1, 0, 0, 0, 8'd0, 8'd0, 5'b10100, "rst_assert");
    idle_cyc(5'b00010, "after_rst");
    cyc(0, 1, 0, 0, 8'd0, 8'd0, 5'b00010, "start_after_rst");
    wave41(2, "defaults_after_rst");

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_queue: got %0d entries left expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
